// File: rtl/imm_pkg.sv
// Shared opcode constants, immediate format codes and skid-buffer states
// for the decode-stage immediate generator.
package imm_pkg;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_IMM32  = 7'h1B;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_OP32   = 7'h3B;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction for all RV32I/RV64I formats.
// Produces the XLEN-wide immediate, its format code and an illegal flag.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  localparam bit IS64 = (XLEN == 64);

  logic [6:0]  opc;
  logic        is_sh;
  logic        sh6;
  logic [5:0]  shamt;
  logic [31:0] raw;

  assign opc   = instr[6:0];
  assign is_sh = (instr[14:12] == 3'b001) || (instr[14:12] == 3'b101);
  // Only 64-bit OP-IMM shifts use the sixth shamt bit
  assign sh6   = IS64 && (opc == OP_IMM);
  assign shamt = {instr[25] & sh6, instr[24:20]};

  always_comb begin
    fmt     = FMT_NONE;
    illegal = 1'b0;
    unique case (opc)
      OP_LOAD, OP_JALR, OP_SYSTEM: fmt = FMT_I;
      OP_IMM: fmt = is_sh ? FMT_SHAMT : FMT_I;
      OP_IMM32: begin
        if (IS64) fmt = is_sh ? FMT_SHAMT : FMT_I;
        else      illegal = 1'b1;
      end
      OP_STORE:        fmt = FMT_S;
      OP_BRANCH:       fmt = FMT_B;
      OP_LUI, OP_AUIPC: fmt = FMT_U;
      OP_JAL:          fmt = FMT_J;
      OP_OP:           fmt = FMT_NONE;
      OP_OP32:         illegal = !IS64;
      default:         illegal = 1'b1;
    endcase
  end

  always_comb begin
    raw = '0;
    unique case (fmt)
      FMT_I: raw = {{20{instr[31]}}, instr[31:20]};
      FMT_S: raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: raw = {{19{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
      FMT_U: raw = {instr[31:12], 12'b0};
      FMT_J: raw = {{11{instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};
      default: raw = '0;
    endcase
  end

  always_comb begin
    if (fmt == FMT_SHAMT) imm = XLEN'(shamt);
    else                  imm = XLEN'($signed(raw));
  end

endmodule

// File: rtl/immediate_gen_pipe.sv
// Pipelined immediate generator: decode in front of a two-entry skid
// buffer giving one-cycle latency, full throughput, registered ready.
module immediate_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [2:0]       fmt_o,
  output logic             illegal_o,
  output logic [TAG_W-1:0] tag_o
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    fmt_e             fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } ent_t;

  skid_e state_q, state_d;
  ent_t  main_q, main_d;
  ent_t  skid_q, skid_d;
  logic  in_ready_q, in_ready_d;
  ent_t  dec;
  logic  accept, drain;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .instr   (instr_i),
    .imm     (dec.imm),
    .fmt     (dec.fmt),
    .illegal (dec.illegal)
  );
  assign dec.tag = tag_i;

  assign out_valid_o = (state_q != ST_EMPTY);
  assign in_ready_o  = in_ready_q;
  assign imm_o       = main_q.imm;
  assign fmt_o       = main_q.fmt;
  assign illegal_o   = main_q.illegal;
  assign tag_o       = main_q.tag;

  assign accept = in_valid_i & in_ready_q;
  assign drain  = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = dec;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_d = dec;
          end else if (accept) begin
            skid_d  = dec;
            state_d = ST_TWO;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (drain) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    // Ready is the registered complement of the skid entry being occupied
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule
